// File: rtl/psone_key_filter.sv
// Multi-channel key filter: per-key two-flop synchroniser, saturating debouncer,
// registered press/release edge pulses and an optional auto-repeat scheduler.
module psone_key_filter #(
    parameter int NUM_KEYS   = 16,
    parameter int DEB_LEN    = 1024,
    parameter int ACTIVE_LOW = 1,
    parameter int REP_DELAY  = 16384,
    parameter int REP_PERIOD = 4096
) (
    input  logic                iCLK,
    input  logic                iRESET,
    input  logic [NUM_KEYS-1:0] iKEY,
    input  logic                iREP_EN,
    output logic [NUM_KEYS-1:0] oKEY,
    output logic [NUM_KEYS-1:0] oPRESS,
    output logic [NUM_KEYS-1:0] oREP,
    output logic [NUM_KEYS-1:0] oRELEASE
);

    localparam int CNT_W   = $clog2(DEB_LEN + 1);
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RCNT_W  = $clog2(REP_MAX + 1);

    localparam logic [CNT_W-1:0]  DEB_MAX     = CNT_W'(DEB_LEN);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REP_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RPT  = 2'd2
    } rep_state_t;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        logic              key_n_s;
        logic              s0_r;
        logic              s1_r;
        logic [CNT_W-1:0]  cnt_r;
        logic              level_r;
        logic              level_nxt_s;
        rep_state_t        state_r;
        rep_state_t        state_nxt_s;
        logic [RCNT_W-1:0] rcnt_r;
        logic [RCNT_W-1:0] rcnt_nxt_s;
        logic              rep_fire_s;
        logic              press_r;
        logic              rep_r;
        logic              release_r;

        // The synchroniser reset value of 0 means "released" in either polarity.
        assign key_n_s = (ACTIVE_LOW != 0) ? ~iKEY[i] : iKEY[i];

        // Synchroniser, saturating stability counter and accepted level.
        always_ff @(posedge iCLK or negedge iRESET) begin
            if (!iRESET) begin
                s0_r    <= 1'b0;
                s1_r    <= 1'b0;
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= 1'b0;
            end else begin
                s0_r <= key_n_s;
                s1_r <= s0_r;
                if (s0_r != s1_r) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (cnt_r != DEB_MAX) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
                level_r <= level_nxt_s;
            end
        end

        // Level accepted only once the synchronised input has been stable long enough.
        always_comb begin
            level_nxt_s = level_r;
            if (cnt_r == DEB_MAX) begin
                level_nxt_s = s1_r;
            end else begin
                level_nxt_s = level_r;
            end
        end

        // Repeat scheduler state register.
        always_ff @(posedge iCLK or negedge iRESET) begin
            if (!iRESET) begin
                state_r <= ST_IDLE;
                rcnt_r  <= {RCNT_W{1'b0}};
            end else begin
                state_r <= state_nxt_s;
                rcnt_r  <= rcnt_nxt_s;
            end
        end

        // Repeat scheduler: a falling level or disabled repeat cancels in the same cycle,
        // which is also what lets a release beat a coincident repeat.
        always_comb begin
            state_nxt_s = state_r;
            rcnt_nxt_s  = rcnt_r;
            rep_fire_s  = 1'b0;
            if (!level_nxt_s || !iREP_EN) begin
                state_nxt_s = ST_IDLE;
                rcnt_nxt_s  = {RCNT_W{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (!level_r) begin
                            state_nxt_s = ST_WAIT;
                            rcnt_nxt_s  = {RCNT_W{1'b0}};
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end
                    ST_WAIT: begin
                        if (rcnt_r == DELAY_LAST) begin
                            rep_fire_s  = 1'b1;
                            state_nxt_s = ST_RPT;
                            rcnt_nxt_s  = {RCNT_W{1'b0}};
                        end else begin
                            rcnt_nxt_s = rcnt_r + RCNT_W'(1);
                        end
                    end
                    ST_RPT: begin
                        if (rcnt_r == PERIOD_LAST) begin
                            rep_fire_s = 1'b1;
                            rcnt_nxt_s = {RCNT_W{1'b0}};
                        end else begin
                            rcnt_nxt_s = rcnt_r + RCNT_W'(1);
                        end
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                        rcnt_nxt_s  = {RCNT_W{1'b0}};
                    end
                endcase
            end
        end

        // Registered pulses aligned with the first cycle of the new level.
        always_ff @(posedge iCLK or negedge iRESET) begin
            if (!iRESET) begin
                press_r   <= 1'b0;
                rep_r     <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= (level_nxt_s & ~level_r) | rep_fire_s;
                rep_r     <= rep_fire_s;
                release_r <= ~level_nxt_s & level_r;
            end
        end

        assign oKEY[i]     = level_r;
        assign oPRESS[i]   = press_r;
        assign oREP[i]     = rep_r;
        assign oRELEASE[i] = release_r;
    end

endmodule

// File: tb/tb_psone_key_filter.sv
// Scoreboard bench for psone_key_filter: a cycle-level reference model queues the
// expected outputs at each clock edge and a negedge monitor compares the DUT.
module tb_psone_key_filter;

    localparam int NK  = 4;
    localparam int DL  = 4;
    localparam int D   = 10;
    localparam int PER = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_raw;
    logic          rep_en;
    logic [NK-1:0] o_key, o_press, o_rep, o_release;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NK-1:0] key;
        logic [NK-1:0] press;
        logic [NK-1:0] rep;
        logic [NK-1:0] rel;
    } exp_t;

    exp_t exp_q[$];

    bit hist[NK][$];
    bit lvl[NK];
    bit armed[NK];
    int age[NK];

    psone_key_filter #(
        .NUM_KEYS(NK), .DEB_LEN(DL), .ACTIVE_LOW(1), .REP_DELAY(D), .REP_PERIOD(PER)
    ) dut (
        .iCLK(clk), .iRESET(rst_n), .iKEY(key_raw), .iREP_EN(rep_en),
        .oKEY(o_key), .oPRESS(o_press), .oREP(o_rep), .oRELEASE(o_release)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NK; c++) begin
            hist[c].delete();
            hist[c].push_back(1'b0);
            hist[c].push_back(1'b0);
            lvl[c]   = 1'b0;
            armed[c] = 1'b0;
            age[c]   = 0;
        end
        exp_q.delete();
    endtask

    // Reference: the level takes the sample from two edges ago once the last DL+1
    // samples (reset counting as two released samples) agree; repeats are timed
    // from the press cycle by plain arithmetic.
    task automatic model_step();
        exp_t e;
        e.key = '0; e.press = '0; e.rep = '0; e.rel = '0;
        for (int c = 0; c < NK; c++) begin
            bit x, nl, pr, rl, rp, stable;
            int L;
            x = ~key_raw[c];
            hist[c].push_back(x);
            L  = hist[c].size();
            nl = lvl[c];
            if (L >= DL + 3) begin
                stable = 1'b1;
                for (int j = L - 3 - DL; j <= L - 3; j++)
                    if (hist[c][j] != hist[c][L-3]) stable = 1'b0;
                if (stable) nl = hist[c][L-3];
            end
            while (hist[c].size() > DL + 3) void'(hist[c].pop_front());
            pr = nl && !lvl[c];
            rl = !nl && lvl[c];
            rp = 1'b0;
            if (pr) begin
                armed[c] = rep_en;
                age[c]   = 0;
            end else if (armed[c]) begin
                if (!nl || !rep_en) armed[c] = 1'b0;
                else begin
                    age[c]++;
                    if (age[c] == D || (age[c] > D && (age[c] - D) % PER == 0)) rp = 1'b1;
                end
            end
            lvl[c]     = nl;
            e.key[c]   = nl;
            e.press[c] = pr | rp;
            e.rep[c]   = rp;
            e.rel[c]   = rl;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("oKEY", o_key, e.key);
                check("oPRESS", o_press, e.press);
                check("oREP", o_rep, e.rep);
                check("oRELEASE", o_release, e.rel);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, "_key"}, o_key, 4'b0000);
        check({name, "_press"}, o_press, 4'b0000);
        check({name, "_rep"}, o_rep, 4'b0000);
        check({name, "_rel"}, o_release, 4'b0000);
    endtask

    initial begin
        rst_n   = 1'b0;
        key_raw = 4'b1111;
        rep_en  = 1'b0;
        #1;
        check_zero("reset");
        tick(3);
        #2 rst_n = 1'b1;
        tick(10);

        // clean press / release on key 0
        key_raw[0] = 1'b0; tick(12);
        key_raw[0] = 1'b1; tick(12);

        // bounce on key 1, then settle pressed
        for (int i = 0; i < 6; i++) begin
            key_raw[1] = ~key_raw[1];
            tick(2);
        end
        key_raw[1] = 1'b0; tick(12);
        key_raw[1] = 1'b1; tick(12);

        // short glitch on key 2
        key_raw[2] = 1'b0; tick(3);
        key_raw[2] = 1'b1; tick(10);

        // auto-repeat on key 3
        rep_en = 1'b1;
        key_raw[3] = 1'b0; tick(37);
        key_raw[3] = 1'b1; tick(15);

        // repeat cancelled by dropping the enable
        key_raw[3] = 1'b0; tick(12);
        rep_en = 1'b0; tick(20);
        key_raw[3] = 1'b1; tick(12);
        rep_en = 1'b1;

        // level falls exactly when the first repeat is due
        key_raw[3] = 1'b0; tick(10);
        key_raw[3] = 1'b1; tick(12);

        // enable rising while held does not start repeat
        rep_en = 1'b0;
        key_raw[2] = 1'b0; tick(12);
        rep_en = 1'b1; tick(20);
        key_raw[2] = 1'b1; tick(12);

        // reset while key 0 is repeating, key kept held
        key_raw[0] = 1'b0; tick(25);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        tick(1);
        #2 rst_n = 1'b1;
        tick(12);
        key_raw[0] = 1'b1; tick(12);

        // random traffic
        repeat (400) begin
            int idx;
            idx = $urandom_range(0, NK - 1);
            if ($urandom_range(0, 3) == 0) key_raw[idx] = ~key_raw[idx];
            if ($urandom_range(0, 60) == 0) rep_en = ~rep_en;
            tick(1);
        end
        repeat (40) begin
            key_raw = 4'($urandom);
            if ($urandom_range(0, 4) == 0) rep_en = ~rep_en;
            tick($urandom_range(1, 25));
        end
        key_raw = 4'b1111;
        tick(12);

        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psone_key_filter.md
Name: psone_key_filter

Overview:
Parametrised multi-channel successor to the single-key PS1 debouncer. It synchronises and debounces NUM_KEYS raw button lines in parallel, presenting one stable level per key. It emits one-cycle press and release pulses, plus optional auto-repeat press pulses while a key is held. It sits between the PS1 controller bit-capture logic and the USB HID report builder.

Parameters:
NUM_KEYS, 16, number of independent key channels (>=1)
DEB_LEN, 1024, stable cycles required before a level is accepted (>=1); counter width CNT_W = $clog2(DEB_LEN+1)
ACTIVE_LOW, 1, 1: raw iKEY low = pressed (inverted at sync input); 0: high = pressed
REP_DELAY, 16384, cycles from press pulse to first repeat pulse (>=1)
REP_PERIOD, 4096, cycles between subsequent repeat pulses (>=1); repeat counter width = $clog2(max(REP_DELAY,REP_PERIOD)+1)

Ports:
iCLK  input  1  clock
iRESET  input  1  reset, asynchronous, active-low
iKEY  input  NUM_KEYS  raw asynchronous key lines
iREP_EN  input  1  global auto-repeat enable (synchronous to iCLK)
oKEY  output  NUM_KEYS  debounced level, 1 = pressed
oPRESS  output  NUM_KEYS  one-cycle pulse on press edge or repeat event
oREP  output  NUM_KEYS  one-cycle pulse, high only when the oPRESS pulse is a repeat
oRELEASE  output  NUM_KEYS  one-cycle pulse on release edge

Behaviour:
- Reset (async, iRESET=0): all sync flops, counters, levels and repeat state go to 0. oKEY, oPRESS, oREP and oRELEASE are 0 immediately. The sync reset value means "released" in both polarities.
- Per channel i:
  - Two-flop sync s0 <= key_n, s1 <= s0, where key_n = ACTIVE_LOW ? ~iKEY[i] : iKEY[i].
  - Debounce counter: if s0 != s1, cnt <= 0. Else if cnt != DEB_LEN, cnt <= cnt+1 (saturates at DEB_LEN).
  - Level: when cnt == DEB_LEN, level <= s1; otherwise it holds. oKEY[i] = level.
- Latency: if a step on iKEY is first sampled at edge 1 and stays stable, oKEY changes after edge DEB_LEN+3.
- Any change on s0/s1 before the counter saturates restarts the count. Glitches shorter than DEB_LEN+1 cycles never reach oKEY.
- Edge pulses are registered: oPRESS[i] and oRELEASE[i] are high exactly in the first cycle oKEY[i] reads 1 or 0 respectively. Never high in consecutive cycles from the same edge.
- Auto-repeat FSM per channel, states IDLE, WAIT, RPT:
  - IDLE -> WAIT on a press edge when iREP_EN=1; the repeat counter is cleared.
  - WAIT: if cycle P is the press-pulse cycle, a repeat pulse fires in cycle P+REP_DELAY, then the FSM goes to RPT.
  - RPT: a repeat pulse fires every REP_PERIOD cycles, at P+REP_DELAY+k*REP_PERIOD.
  - Repeat pulse: oPRESS[i]=1 and oREP[i]=1 for one cycle.
  - Any state -> IDLE (counter cleared) when level=0 or iREP_EN=0. This takes effect the same cycle, so no repeat pulse fires in that cycle.
  - Release and scheduled repeat in the same cycle: release wins; oRELEASE=1, oPRESS=oREP=0.
  - iREP_EN rising while a key is already held does not start repeat. Repeat starts only at the next press edge.
- oREP implies oPRESS. oPRESS and oRELEASE are never high together on one channel.
- Channels are fully independent. Simultaneous events on different channels all produce pulses in the same cycle.
- Reset mid-operation (key held, FSM in RPT): outputs go to 0. After reset release with the key still pressed, this is a fresh press: oKEY rises after DEB_LEN+3 edges with one oPRESS.

Test Plan:
Use params NUM_KEYS=4, DEB_LEN=4, ACTIVE_LOW=1, REP_DELAY=10, REP_PERIOD=3.
- Clean press/release: iKEY[0] 1->0 first sampled at edge 1 -> oKEY[0]=1 after edge 7, with oPRESS[0]=1 for exactly that cycle. Then 0->1 -> oKEY[0]=0 seven edges later, with a single oRELEASE[0].
- Bounce: iKEY[1] toggles every 2 cycles for 12 cycles, then stays 0 -> no oKEY change during bouncing. oKEY[1]=1 at 7 edges after the last toggle, with exactly one oPRESS.
- Glitch: iKEY[2] low for 3 cycles, then high -> oKEY, oPRESS and oRELEASE all stay 0.
- Repeat: iREP_EN=1, hold key 3 for 30 cycles past press cycle P -> oPRESS[3] at P, P+10, P+13, P+16, ...; oREP[3] on all except P. Release -> one oRELEASE[3] and no further oPRESS.
- Repeat cancel/priority:
  - Drop iREP_EN at P+5 -> no repeat pulses.
  - Release so the level falls exactly at P+10 -> oRELEASE=1, oPRESS=0 in that cycle.
- Reset mid-hold: key 0 in RPT, pulse iRESET low for 1 cycle -> all outputs 0 asynchronously. With the key still held, oKEY[0]=1 and one oPRESS[0] after DEB_LEN+3 edges.
